// File: rtl/display_control_pkg.sv
// Shared constants and types for the display side and the gameplay controller.
package display_control_pkg;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned BLK_W = 16;
    localparam int unsigned BLK_H = 8;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;

    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_END  = 2'b10;

    localparam logic [C_W-1:0] COL_BG  = 3'b000;
    localparam logic [C_W-1:0] COL_END = 3'b100;

    typedef enum logic [2:0] {
        S_WAIT,
        S_LATCH,
        S_ERASE,
        S_DRAW,
        S_DONE,
        S_END_FILL,
        S_END_HOLD
    } disp_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/display_control_if.sv
// Gameplay-side inputs and VGA-side outputs of the display controller.
interface display_control_if;
    import display_control_pkg::*;

    logic [1:0]     game_status;
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic [C_W-1:0] colour_in;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;
    logic           frame_done;
    logic           busy;

    modport master (
        input  game_status, x_in, y_in, colour_in,
        output vga_x, vga_y, vga_colour, vga_plot, frame_done, busy
    );

    modport slave (
        output game_status, x_in, y_in, colour_in,
        input  vga_x, vga_y, vga_colour, vga_plot, frame_done, busy
    );
endinterface

// File: rtl/display_control_rect_sweeper.sv
// Row-major rectangle sweeper: one pixel per clock, clipped to the screen.
module display_control_rect_sweeper
    import display_control_pkg::*;
#(
    parameter int unsigned SWP_SCR_W = SCR_W,
    parameter int unsigned SWP_SCR_H = SCR_H
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic [C_W-1:0] colour,
    output pixel_t         pix,
    output logic           plot,
    output logic           last_c
);

    logic           active;
    logic [X_W-1:0] bx, bw, col, n_bx, n_bw, n_col;
    logic [Y_W-1:0] by, bh, row, n_by, n_bh, n_row;
    logic [C_W-1:0] bc, n_bc;
    logic [X_W:0]   sum_x;
    logic [Y_W:0]   sum_y;
    logic           on_screen;

    // The pixel currently on the outputs is the final one of the rectangle
    assign last_c = active && (col == bw - 8'd1) && (row == bh - 7'd1);

    // Next pixel position: restart on start, else advance column-first
    always_comb begin
        n_bx  = bx;
        n_by  = by;
        n_bw  = bw;
        n_bh  = bh;
        n_bc  = bc;
        n_col = col;
        n_row = row;
        if (start) begin
            n_bx  = base_x;
            n_by  = base_y;
            n_bw  = w;
            n_bh  = h;
            n_bc  = colour;
            n_col = '0;
            n_row = '0;
        end else if (col == bw - 8'd1) begin
            n_col = '0;
            n_row = row + 7'd1;
        end else begin
            n_col = col + 8'd1;
        end
        sum_x     = {1'b0, n_bx} + {1'b0, n_col};
        sum_y     = {1'b0, n_by} + {1'b0, n_row};
        on_screen = (sum_x < 9'(SWP_SCR_W)) && (sum_y < 8'(SWP_SCR_H));
    end

    // Sweep counters and registered pixel outputs; off-screen pixels hold the last coordinate
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            bx     <= '0;
            by     <= '0;
            bw     <= '0;
            bh     <= '0;
            bc     <= '0;
            col    <= '0;
            row    <= '0;
            pix    <= '0;
            plot   <= 1'b0;
        end else if (start || (active && !last_c)) begin
            active <= 1'b1;
            bx     <= n_bx;
            by     <= n_by;
            bw     <= n_bw;
            bh     <= n_bh;
            bc     <= n_bc;
            col    <= n_col;
            row    <= n_row;
            plot   <= on_screen;
            if (on_screen) begin
                pix.x      <= sum_x[X_W-1:0];
                pix.y      <= sum_y[Y_W-1:0];
                pix.colour <= n_bc;
            end
        end else begin
            active <= 1'b0;
            plot   <= 1'b0;
        end
    end

endmodule

// File: rtl/display_control.sv
// Per-frame erase/draw of the moving block, plus game-over screen fill.
module display_control
    import display_control_pkg::*;
#(
    parameter int unsigned    SCREEN_W   = SCR_W,
    parameter int unsigned    SCREEN_H   = SCR_H,
    parameter int unsigned    BLOCK_W    = BLK_W,
    parameter int unsigned    BLOCK_H    = BLK_H,
    parameter int unsigned    FRAME_DIV  = 833334,
    parameter logic [C_W-1:0] BG_COLOUR  = COL_BG,
    parameter logic [C_W-1:0] END_COLOUR = COL_END
) (
    input  logic              clk,
    input  logic              resetn,
    display_control_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_DIV);

    disp_state_t    state, next_state;
    logic [CNT_W-1:0] frame_cnt;
    logic           tick_c, erase_c;
    logic [X_W-1:0] cur_x, prev_x;
    logic [Y_W-1:0] cur_y, prev_y;
    logic [C_W-1:0] cur_col;
    logic           have_prev;
    logic           frame_done_q, busy_q, frame_done_d, busy_d;
    logic           sw_start, sw_last, sw_plot;
    logic [X_W-1:0] sw_bx, sw_w;
    logic [Y_W-1:0] sw_by, sw_h;
    logic [C_W-1:0] sw_col;
    pixel_t         sw_pix;

    assign tick_c  = (frame_cnt == CNT_W'(FRAME_DIV - 1));
    assign erase_c = have_prev && (bus.y_in == prev_y);

    // Free-running frame divider
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) frame_cnt <= '0;
        else if (tick_c) frame_cnt <= '0;
        else frame_cnt <= frame_cnt + CNT_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_WAIT;
        else state <= next_state;
    end

    // Next-state logic; game over is checked ahead of the frame tick
    always_comb begin
        next_state = state;
        case (state)
            S_WAIT: begin
                if (bus.game_status == ST_END) next_state = S_END_FILL;
                else if (tick_c && bus.game_status == ST_PLAY) next_state = S_LATCH;
            end
            S_LATCH:    next_state = erase_c ? S_ERASE : S_DRAW;
            S_ERASE:    if (sw_last) next_state = S_DRAW;
            S_DRAW:     if (sw_last) next_state = S_DONE;
            S_DONE:     next_state = S_WAIT;
            S_END_FILL: if (sw_last) next_state = S_END_HOLD;
            S_END_HOLD: if (bus.game_status != ST_END) next_state = S_WAIT;
            default:    next_state = S_WAIT;
        endcase
    end

    // Sweeper launch control and next values of the registered status outputs
    always_comb begin
        sw_start = 1'b0;
        sw_bx    = cur_x;
        sw_by    = cur_y;
        sw_w     = 8'(BLOCK_W);
        sw_h     = 7'(BLOCK_H);
        sw_col   = cur_col;
        case (state)
            S_WAIT: begin
                if (bus.game_status == ST_END) begin
                    sw_start = 1'b1;
                    sw_bx    = '0;
                    sw_by    = '0;
                    sw_w     = 8'(SCREEN_W);
                    sw_h     = 7'(SCREEN_H);
                    sw_col   = END_COLOUR;
                end
            end
            S_LATCH: begin
                sw_start = 1'b1;
                if (erase_c) begin
                    sw_bx  = prev_x;
                    sw_by  = prev_y;
                    sw_col = BG_COLOUR;
                end else begin
                    sw_bx  = bus.x_in;
                    sw_by  = bus.y_in;
                    sw_col = bus.colour_in;
                end
            end
            S_ERASE: sw_start = sw_last;
            default: ;
        endcase
        frame_done_d = (next_state == S_DONE);
        busy_d       = !((next_state == S_WAIT) || (next_state == S_END_HOLD));
    end

    // Block position bookkeeping and status output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_x        <= '0;
            cur_y        <= '0;
            cur_col      <= '0;
            prev_x       <= '0;
            prev_y       <= '0;
            have_prev    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            if (state == S_LATCH) begin
                cur_x   <= bus.x_in;
                cur_y   <= bus.y_in;
                cur_col <= bus.colour_in;
            end
            if (state == S_DONE) begin
                prev_x    <= cur_x;
                prev_y    <= cur_y;
                have_prev <= 1'b1;
            end
            if (state == S_END_HOLD && next_state == S_WAIT) have_prev <= 1'b0;
        end
    end

    display_control_rect_sweeper #(
        .SWP_SCR_W(SCREEN_W),
        .SWP_SCR_H(SCREEN_H)
    ) u_sweeper (
        .clk    (clk),
        .resetn (resetn),
        .start  (sw_start),
        .base_x (sw_bx),
        .base_y (sw_by),
        .w      (sw_w),
        .h      (sw_h),
        .colour (sw_col),
        .pix    (sw_pix),
        .plot   (sw_plot),
        .last_c (sw_last)
    );

    assign bus.vga_x      = sw_pix.x;
    assign bus.vga_y      = sw_pix.y;
    assign bus.vga_colour = sw_pix.colour;
    assign bus.vga_plot   = sw_plot;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule
